elastic_pipeline_register: RTL and testbench
============================================

// Module: elastic_pipeline_register
// PURPOSE
//   Parametrised successor of the fixed inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Chain of STAGES registers, each DATA_W wide, with per-stage valid bits and valid/ready handshake.
//   Supports backpressure (stall), bubble collapsing, per-stage flush and an occupancy count.
//   Sits between processor stages so hazard/branch logic can stall and squash without ad-hoc muxing.
// PARAMETERS
//   DATA_W  32  payload width in bits (>=1)
//   STAGES  2   number of register stages in the chain (>=1)
//   OCC_W   localparam = $clog2(STAGES+2); width of occupancy_o
// PORTS
//   clk          in   1       clock, all state on rising edge
//   reset        in   1       asynchronous, active-low reset
//   in_valid_i   in   1       upstream word valid
//   in_ready_o   out  1       chain can accept a word this cycle
//   in_data_i    in   DATA_W  upstream payload
//   out_valid_o  out  1       head word valid
//   out_ready_i  in   1       downstream accepts head word this cycle
//   out_data_o   out  DATA_W  head payload
//   flush_i      in   STAGES  per-stage squash; bit k kills the word entering stage k
//   occupancy_o  out  OCC_W   number of valid words held
// BEHAVIOUR
//   - One clock clk; reset is asynchronous and active-low. While reset=0: all valid bits 0, all data
//     registers 0, skid empty; out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1.
//   - Stage k holds valid_q[k], data_q[k]; stage 0 is the input end, stage STAGES-1 the head.
//   - rdy[STAGES] = out_ready_i (or !skid_full, see CONFIGURATION); rdy[k] = !valid_q[k] | rdy[k+1].
//   - in_ready_o = rdy[0]. Upstream transfer when in_valid_i & in_ready_o.
//   - Each edge where rdy[k]=1: valid_q[k] <= src_valid & ~flush_i[k]; data_q[k] <= src_data only if
//     src_valid (else data holds). src = input for k=0, stage k-1 otherwise. rdy[k]=0: stage holds.
//   - Bubble collapsing: an empty stage accepts even when the stage ahead is stalled.
//   - Latency: STAGES cycles from accept to out_valid_o with no backpressure; throughput 1 word/cycle.
//   - Words emerge strictly in acceptance order; no loss or duplication except flushed words.
//   - flush_i has no combinational path to in_ready_o or out_valid_o; it acts only at the next edge.
//   - Flush of a stage with rdy[k]=0 has no effect (holding word is kept); squash applies on movement.
//   - out_valid_o = valid_q[STAGES-1]; out_data_o = data_q[STAGES-1]. Downstream transfer when
//     out_valid_o & out_ready_i; accepting and emitting in the same cycle with a full chain is allowed.
//   - occupancy_o = popcount of valid bits (+1 if skid full), registered-state derived, no in_* path.
//   - Reset asserted mid-operation: all contents discarded immediately, outputs to reset values.
// CONFIGURATION
//   - Macro ELASTIC_PIPE_SKID_BUFFER_EN.
//   - Defined: one-entry skid buffer after the head stage; rdy[STAGES] = !skid_full, so no
//     combinational path from out_ready_i to in_ready_o. Head word moving while out_ready_i=0 is
//     captured into skid; out_valid_o = skid_full | valid_q[STAGES-1], skid has priority for output.
//     Capacity STAGES+1; latency unchanged. flush_i[STAGES-1] also empties the skid at the next edge.
//   - Undefined: no skid, capacity STAGES, in_ready_o may depend combinationally on out_ready_i.
// TESTING
//   - Reset: reset=0 with random inputs -> out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1.
//   - Streaming (STAGES=2): push 0x01..0x10 back-to-back, out_ready_i=1 -> 0x01 valid 2 cycles
//     after first accept, then one word/cycle, in order, in_ready_o stays 1.
//   - Backpressure: out_ready_i=0, offer 5 words -> 2 accepted (3 with skid), in_ready_o=0,
//     occupancy_o=2 (3); release out_ready_i -> accepted words drain in order, none lost/duplicated.
//   - Bubble collapse: push A, idle 1 cycle, push B with out_ready_i=0 -> both held, occupancy_o=2,
//     output A then B once out_ready_i=1.
//   - Flush: stream 0x01..0x08, assert flush_i=2'b01 for the cycle 0x04 is accepted -> output
//     sequence 0x01,0x02,0x03,0x05..0x08; flush_i=2'b10 on stalled full chain -> no change.
//   - Reset mid-operation: occupancy_o=2, pull reset low between edges -> out_valid_o drops at once;
//     after release chain empty, next pushed word emerges after STAGES cycles.

Source files
------------

// File: rtl/elastic_pipeline_register.sv
// Elastic valid/ready pipeline register chain with bubble collapsing, per-stage flush and occupancy.
// Optional one-entry output skid buffer enabled by defining ELASTIC_PIPE_SKID_BUFFER_EN.
module elastic_pipeline_register #(
  parameter  int DATA_W = 32,
  parameter  int STAGES = 2,
  localparam int OCC_W  = $clog2(STAGES + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic [STAGES-1:0] flush_i,
  output logic [OCC_W-1:0]  occupancy_o
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [STAGES:0]   rdy;
  logic              head_rdy;

`ifdef ELASTIC_PIPE_SKID_BUFFER_EN
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // The head drains into the skid, which breaks the out_ready_i -> in_ready_o path.
  assign head_rdy    = !skid_full_q;
  assign out_valid_o = skid_full_q | valid_q[STAGES-1];
  assign out_data_o  = skid_full_q ? skid_data_q : data_q[STAGES-1];

  always_comb begin
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    if (skid_full_q) begin
      if (out_ready_i || flush_i[STAGES-1]) skid_full_d = 1'b0;
    end else if (valid_q[STAGES-1] && !out_ready_i) begin
      skid_full_d = 1'b1;
      skid_data_d = data_q[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign head_rdy    = out_ready_i;
  assign out_valid_o = valid_q[STAGES-1];
  assign out_data_o  = data_q[STAGES-1];
`endif

  // Ready ripples back from the head; an empty stage is always ready (bubble collapsing).
  always_comb begin
    logic r;
    r           = head_rdy;
    rdy         = '0;
    rdy[STAGES] = r;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !valid_q[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready_o = rdy[0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    logic [STAGES-1:0] src_valid;
    logic [DATA_W-1:0] src_data [STAGES];
    src_valid[0] = in_valid_i;
    src_data[0]  = in_data_i;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
    end
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) data_d[k] = data_q[k];
    for (int k = 0; k < STAGES; k++) begin
      if (rdy[k]) begin
        valid_d[k] = src_valid[k] & ~flush_i[k];
        if (src_valid[k]) data_d[k] = src_data[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      // NOTE: payload registers are reset too because out_data_o must read zero while in reset.
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < STAGES; k++) occupancy_o = occupancy_o + OCC_W'(valid_q[k]);
`ifdef ELASTIC_PIPE_SKID_BUFFER_EN
    occupancy_o = occupancy_o + OCC_W'(skid_full_q);
`endif
  end

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Self-checking bench: the reference model is a FIFO with a fixed minimum latency and a capacity
// limit; directed scenarios are followed by a randomized run checked against the same model.
module tb_elastic_pipeline_register;

  localparam int DW = 32;
  localparam int S  = 2;
  localparam int OW = $clog2(S + 2);
`ifdef ELASTIC_PIPE_SKID_BUFFER_EN
  localparam int CAP  = S + 1;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = S;
  localparam bit SKID = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [S-1:0]  flush_i;
  logic [OW-1:0] occupancy_o;

  elastic_pipeline_register #(.DATA_W(DW), .STAGES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } word_t;

  word_t         q[$];
  logic [DW-1:0] emitted[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            n_acc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance model at the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic [S-1:0] fl);
    logic exp_ov, exp_ir, acc, lv;
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].acc + S);
    exp_ir = SKID ? (q.size() < CAP) : ((q.size() < S) || ordy);
    check("out_valid", out_valid_o, exp_ov);
    check("in_ready", in_ready_o, exp_ir);
    check("occupancy", occupancy_o, q.size());
    if (exp_ov) check("out_data", out_data_o, q[0].data);
    acc = iv && exp_ir;
    lv  = exp_ov && ordy;
    @(posedge clk);
    if (lv) begin
      emitted.push_back(q[0].data);
      void'(q.pop_front());
    end
    if (acc) begin
      n_acc++;
      if (!fl[0]) q.push_back('{data: d, acc: cyc});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, '0);
  endtask

  initial begin
    logic [DW-1:0] flush_exp [7];
    flush_exp = '{32'h1, 32'h2, 32'h3, 32'h5, 32'h6, 32'h7, 32'h8};

    // Reset held with random inputs
    reset = 1'b0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0; flush_i = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid_i  = 1'($urandom);
      in_data_i   = $urandom;
      out_ready_i = 1'($urandom);
      flush_i     = S'($urandom);
      #1;
      check("rst_out_valid", out_valid_o, 1'b0);
      check("rst_out_data", out_data_o, '0);
      check("rst_occupancy", occupancy_o, '0);
      check("rst_in_ready", in_ready_o, 1'b1);
      @(negedge clk);
    end
    reset = 1'b1;

    // Streaming 0x01..0x10
    emitted.delete();
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b1, '0);
    drain(S + 2);
    check("stream_count", emitted.size(), 16);
    for (int i = 0; i < emitted.size(); i++) check("stream_order", emitted[i], DW'(i + 1));

    // Backpressure: offer five words into a stalled chain
    emitted.delete();
    n_acc = 0;
    for (int i = 0; i < 5; i++) step(1'b1, DW'(32'hA0 + i), 1'b0, '0);
    check("bp_accepted", n_acc, CAP);
    check("bp_occupancy", occupancy_o, CAP);
    drain(CAP + 2);
    check("bp_count", emitted.size(), CAP);
    for (int i = 0; i < emitted.size(); i++) check("bp_order", emitted[i], DW'(32'hA0 + i));

    // Bubble collapse
    emitted.delete();
    step(1'b1, 32'hB1, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b1, 32'hB2, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    check("bubble_occ", occupancy_o, 2);
    drain(S + 2);
    check("bubble_count", emitted.size(), 2);
    for (int i = 0; i < emitted.size(); i++) check("bubble_order", emitted[i], DW'(32'hB1 + i));

    // Flush stage 0 while 0x04 is accepted
    emitted.delete();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, (i == 4) ? S'(1) : S'(0));
    drain(S + 2);
    check("flush_count", emitted.size(), 7);
    for (int i = 0; i < emitted.size(); i++) check("flush_order", emitted[i], flush_exp[i]);

    // Flush head on a stalled full chain: stages keep their words, a full skid is emptied
    emitted.delete();
    for (int i = 0; i <= CAP; i++) step(1'b1, DW'(32'hC0 + i), 1'b0, '0);
    step(1'b0, '0, 1'b0, S'(1) << (S - 1));
    if (SKID) void'(q.pop_front());
    step(1'b0, '0, 1'b0, '0);
    drain(CAP + 2);
    check("stall_flush_count", emitted.size(), S);
    check("stall_flush_first", emitted[0], SKID ? 32'hC1 : 32'hC0);

    // Reset mid-operation
    emitted.delete();
    step(1'b1, 32'hD1, 1'b0, '0);
    step(1'b1, 32'hD2, 1'b0, '0);
    #1;
    check("midrst_occ_before", occupancy_o, 2);
    #1 reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_o, 1'b0);
    check("midrst_occupancy", occupancy_o, '0);
    check("midrst_in_ready", in_ready_o, 1'b1);
    check("midrst_out_data", out_data_o, '0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 32'hD3, 1'b1, '0);
    drain(S + 1);
    check("midrst_count", emitted.size(), 1);
    check("midrst_word", emitted[0], 32'hD3);

    // Randomized traffic with occasional stage-0 squash
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           {1'b0, $urandom_range(0, 9) == 0});
    drain(CAP + 3);
    check("rand_drained", occupancy_o, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
